// File: rtl/imem_loader.sv
// Byte-stream boot loader: frames of SYNC, LEN, LEN data bytes and an 8-bit
// additive checksum are written into instruction memory while the CPU is held in reset.
module imem_loader #(
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cpu_rst,
  output logic       done,
  output logic       err,
  output logic [2:0] state_dbg
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // the producer holds in_data stable while in_valid is high and not accepted.
  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t     state;
  logic [8:0] remaining;
  logic [7:0] addr;
  logic [7:0] sum;
  logic       xfer;

  assign in_ready  = (state != S_DONE);
  assign xfer      = in_valid && in_ready;
  assign state_dbg = state;

  // done/err/cpu_rst are updated together with the state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SYNC;
      remaining <= 9'd0;
      addr      <= 8'd0;
      sum       <= 8'd0;
      wr_en     <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 8'd0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (xfer) begin
        case (state)
          S_SYNC: begin
            if (in_data == SYNC) state <= S_LEN;
          end
          S_LEN: begin
            // A length byte of zero denotes a full 256-byte image.
            remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            addr      <= 8'd0;
            sum       <= 8'd0;
            state     <= S_DATA;
          end
          S_DATA: begin
            wr_en     <= 1'b1;
            wr_addr   <= addr;
            wr_data   <= in_data;
            addr      <= addr + 8'd1;
            sum       <= sum + in_data;
            remaining <= remaining - 9'd1;
            if (remaining == 9'd1) state <= S_CHK;
          end
          S_CHK: begin
            if (in_data == sum) begin
              state   <= S_DONE;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          S_ERR: begin
            if (in_data == SYNC) begin
              state <= S_LEN;
              err   <= 1'b0;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
